// File: rtl/rr_arb_pkg.sv
// Shared types and round-robin search helper for rr_arbiter8.
// Latency: n/a (constants, types and a combinational function only).
// Backpressure: n/a.
package rr_arb_pkg;

    localparam int N_REQ = 8;
    localparam int IDX_W = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
    } rr_pick_t;

    // Walks offsets from the highest down, so the lowest offset from ptr is the last one written.
    function automatic rr_pick_t rr_find_first(input logic [N_REQ-1:0] req,
                                               input logic [IDX_W-1:0] ptr);
        rr_pick_t         pick;
        logic [IDX_W-1:0] cand;
        pick = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            cand = ptr + IDX_W'(i);
            if (req[cand]) begin
                pick.found = 1'b1;
                pick.idx   = cand;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/onehot_dec3.sv
// 3-bit index plus enable to 8-bit one-hot decode.
// Latency: combinational.
// Backpressure: none.
module onehot_dec3 (
    input  logic [2:0] idx,
    input  logic       en,
    output logic [7:0] onehot
);

    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/rr_arbiter8.sv
// Round-robin 8-way locked-grant arbiter; optional forced release via ARB_TIMEOUT_EN.
// Latency: request sampled at an edge is granted on that edge; one dead cycle between owners.
// Backpressure: none; a requester holds req until done, the owner keeps the grant until it drops req.
module rr_arbiter8
    import rr_arb_pkg::*;
`ifdef ARB_TIMEOUT_EN
#(
    parameter int TIMEOUT_CYCLES = 16
)
`endif
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic             gnt_valid,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_timeout
);

    arb_state_t       state;
    arb_state_t       state_nxt;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] ptr_nxt;
    logic [IDX_W-1:0] idx_nxt;
    logic             tmo_fire;
    rr_pick_t         pick;

    assign pick = rr_find_first(req, ptr);

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] tmo_cnt;

    // Counter is zero on the first grant cycle because it is held clear while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt <= '0;
        end else if (state == GRANT) begin
            tmo_cnt <= tmo_cnt + 8'd1;
        end else begin
            tmo_cnt <= '0;
        end
    end

    assign tmo_fire = (state == GRANT) && req[gnt_idx] && (tmo_cnt == TMO_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_timeout <= 1'b0;
        end else begin
            gnt_timeout <= tmo_fire;
        end
    end
`else
    assign tmo_fire    = 1'b0;
    assign gnt_timeout = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        idx_nxt   = gnt_idx;
        case (state)
            IDLE: begin
                if (pick.found) begin
                    state_nxt = GRANT;
                    idx_nxt   = pick.idx;
                end
            end
            GRANT: begin
                if (!req[gnt_idx] || tmo_fire) begin
                    state_nxt = IDLE;
                    ptr_nxt   = gnt_idx + IDX_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            ptr     <= '0;
            gnt_idx <= '0;
        end else begin
            state   <= state_nxt;
            ptr     <= ptr_nxt;
            gnt_idx <= idx_nxt;
        end
    end

    assign gnt_valid = (state == GRANT);

    onehot_dec3 u_dec (
        .idx    (gnt_idx),
        .en     (gnt_valid),
        .onehot (gnt)
    );

endmodule
